ahb_sram_ctrl: RTL and testbench

AHB-Lite slave that converts bus transfers into single-port SRAM cycles for the 16384x32 on-chip memory behind `sram_sp_16384x32_m16_be_wrap`. It sits directly upstream of that SRAM wrapper and drives its CEN/GWEN/BEN/A/D pins. It also consumes the wrapper's Q output. Writes pass through a one-entry write buffer, so every transfer completes with zero wait states (HREADYOUT is always 1), including read-after-write to the same word.

---
 rtl/soc_ahb_pkg.sv | 16 +
 rtl/ahb_sram_ctrl.sv | 88 ++++++++
 tb/tb_ahb_sram_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/soc_ahb_pkg.sv
// soc_ahb_pkg: shared AHB-Lite encodings and byte-lane mask helper
package soc_ahb_pkg;
  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;
  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;
  function automatic logic [3:0] byte_mask(input logic [2:0] size, input logic [1:0] addr);
    return size == HSIZE_BYTE ? 4'b0001 << addr :
           size == HSIZE_HALF ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  endfunction
endpackage

// File: rtl/ahb_sram_ctrl.sv
// ahb_sram_ctrl: zero-wait-state AHB-Lite to single-port SRAM bridge with a one-entry write buffer
module ahb_sram_ctrl
  import soc_ahb_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          HSEL,
  input  logic [31:0]   HADDR,
  input  logic [1:0]    HTRANS,
  input  logic [2:0]    HSIZE,
  input  logic          HWRITE,
  input  logic [31:0]   HWDATA,
  input  logic          HREADY,
  output logic          HREADYOUT,
  output logic          HRESP,
  output logic [31:0]   HRDATA,
  input  logic [31:0]   SRAMQ,
  output logic          SRAMCEN,
  output logic          SRAMGWEN,
  output logic [3:0]    SRAMBEN,
  output logic [AW-3:0] SRAMA,
  output logic [31:0]   SRAMD
);
  logic          valid, rd_ap, wr_ap, direct, flush, load, hit;
  logic          wr_pend, rd_pend, buf_valid;
  logic [AW-3:0] wr_addr, rd_addr, buf_addr;
  logic [3:0]    wr_mask, buf_mask;
  logic [31:0]   buf_data;
  logic          unused;
  assign unused = &{1'b0, HADDR[31:AW], HTRANS[0]};
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  // A read address phase always owns the SRAM port; pending writes yield to it via the buffer.
  assign valid  = HRESETn & HSEL & HREADY & HTRANS[1];
  assign rd_ap  = valid & ~HWRITE;
  assign wr_ap  = valid & HWRITE;
  assign flush  = buf_valid & ~rd_ap;
  assign load   = wr_pend & (rd_ap | buf_valid);
  assign direct = wr_pend & ~rd_ap & ~buf_valid;
  assign hit    = buf_valid & (buf_addr == rd_addr);
  // Capture address-phase information for the following data phase
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      wr_pend <= 1'b0;
      rd_pend <= 1'b0;
      wr_addr <= '0;
      wr_mask <= '0;
      rd_addr <= '0;
    end else if (HREADY) begin
      wr_pend <= wr_ap;
      rd_pend <= rd_ap;
      if (wr_ap) begin
        wr_addr <= HADDR[AW-1:2];
        wr_mask <= byte_mask(HSIZE, HADDR[1:0]);
      end
      if (rd_ap) rd_addr <= HADDR[AW-1:2];
    end
  // Write buffer: reload takes precedence over clear so flush-and-refill works in one cycle
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_mask  <= '0;
      buf_data  <= '0;
    end else if (load) begin
      buf_valid <= 1'b1;
      buf_addr  <= wr_addr;
      buf_mask  <= wr_mask;
      buf_data  <= HWDATA;
    end else if (flush) begin
      buf_valid <= 1'b0;
    end
  // SRAM port: read strobe, buffer flush, direct write, or idle
  always_comb begin
    SRAMCEN  = ~(rd_ap | flush | direct);
    SRAMGWEN = ~(flush | direct);
    SRAMBEN  = flush ? ~buf_mask : direct ? ~wr_mask : 4'hF;
    SRAMA    = rd_ap ? HADDR[AW-1:2] : flush ? buf_addr : direct ? wr_addr : '0;
    SRAMD    = flush ? buf_data : direct ? HWDATA : '0;
  end
  // Read data: SRAM word overlaid with any still-buffered bytes of the same word
  for (genvar b = 0; b < 4; b++) begin : g_lane
    assign HRDATA[8*b+:8] = !rd_pend ? 8'h00 :
                            (hit & buf_mask[b]) ? buf_data[8*b+:8] : SRAMQ[8*b+:8];
  end
endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// tb_ahb_sram_ctrl: scoreboard bench for ahb_sram_ctrl with a behavioural SRAM
module tb_ahb_sram_ctrl;
  import soc_ahb_pkg::*;
  typedef struct packed {
    logic [13:0] a;
    logic [3:0]  ben;
    logic [31:0] d;
  } wr_t;
  logic        HCLK = 1'b0, HRESETn = 1'b0, HSEL = 1'b0, HWRITE = 1'b0, HREADY = 1'b1;
  logic [31:0] HADDR = '0, HWDATA = '0, SRAMQ = '0;
  logic [1:0]  HTRANS = HTRANS_IDLE;
  logic [2:0]  HSIZE = HSIZE_WORD;
  logic        HREADYOUT, HRESP, SRAMCEN, SRAMGWEN;
  logic [31:0] HRDATA, SRAMD;
  logic [3:0]  SRAMBEN;
  logic [13:0] SRAMA;
  bit   [31:0] mem [16384];
  wr_t         wr_q[$];
  logic [31:0] rd_q[$];
  wr_t         e;
  logic        rd_dp, rd_ap;
  int          checks = 0, failures = 0, wr_cnt = 0;

  ahb_sram_ctrl #(.AW(16)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .SRAMQ(SRAMQ),
    .SRAMCEN(SRAMCEN), .SRAMGWEN(SRAMGWEN), .SRAMBEN(SRAMBEN), .SRAMA(SRAMA), .SRAMD(SRAMD)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask

  // Behavioural SRAM: byte-masked writes, Q registered one cycle after a read strobe
  always @(posedge HCLK)
    if (!SRAMCEN) begin
      if (!SRAMGWEN) begin
        for (int b = 0; b < 4; b++)
          if (!SRAMBEN[b]) mem[SRAMA][8*b+:8] <= SRAMD[8*b+:8];
      end else SRAMQ <= mem[SRAMA];
    end

  // Bus-side view of which cycles are read data phases
  assign rd_ap = HRESETn & HSEL & HREADY & HTRANS[1] & ~HWRITE;
  always @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) rd_dp <= 1'b0;
    else if (HREADY) rd_dp <= rd_ap;

  // Monitor: pops expected read data and SRAM writes as the DUT presents them
  always @(negedge HCLK) begin
    chk("hreadyout", {31'b0, HREADYOUT}, 32'd1);
    chk("hresp", {31'b0, HRESP}, 32'd0);
    chk("buf_vs_read_invariant", {31'b0, dut.buf_valid & dut.wr_pend & rd_ap}, 32'd0);
    if (rd_dp) begin
      if (rd_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL rdata_unexpected actual=%h required=none", HRDATA);
      end else chk("rdata", HRDATA, rd_q.pop_front());
    end else chk("rdata_idle", HRDATA, 32'd0);
    if (!SRAMCEN && !SRAMGWEN) begin
      wr_cnt++;
      if (wr_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL sram_write_unexpected actual=%h/%h/%h required=none", SRAMA, SRAMBEN, SRAMD);
      end else begin
        e = wr_q.pop_front();
        chk("sram_a", {18'b0, SRAMA}, {18'b0, e.a});
        chk("sram_ben", {28'b0, SRAMBEN}, {28'b0, e.ben});
        chk("sram_d", SRAMD, e.d);
      end
    end
  end

  task automatic step(input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                      input logic [31:0] a, input logic [31:0] wd);
    HSEL = tr[1]; HTRANS = tr; HWRITE = wr; HSIZE = sz; HADDR = a; HWDATA = wd;
    @(posedge HCLK); #1;
  endtask
  task automatic w(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    step(HTRANS_NONSEQ, 1'b1, sz, a, wd);
  endtask
  task automatic r(input logic [31:0] a, input logic [31:0] wd);
    step(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, a, wd);
  endtask
  task automatic idle(input logic [31:0] wd);
    step(HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0, wd);
  endtask
  task automatic exp_w(input logic [13:0] a, input logic [3:0] ben, input logic [31:0] d);
    wr_q.push_back('{a: a, ben: ben, d: d});
  endtask
  task automatic chk_idle(input string n);
    chk({n, "_cen"}, {31'b0, SRAMCEN}, 32'd1);
    chk({n, "_gwen"}, {31'b0, SRAMGWEN}, 32'd1);
    chk({n, "_ben"}, {28'b0, SRAMBEN}, 32'hF);
    chk({n, "_hrdata"}, HRDATA, 32'd0);
  endtask

  initial begin
    #2 chk_idle("reset");
    @(posedge HCLK); @(posedge HCLK); #1 HRESETn = 1'b1;
    // Direct word write, then read back
    exp_w(14'h4, 4'b0000, 32'hDEADBEEF);
    w(32'h10, HSIZE_WORD, 32'h0); idle(32'hDEADBEEF);
    chk("direct_write_timing", wr_cnt, 1);
    rd_q.push_back(32'hDEADBEEF);
    r(32'h10, 32'h0); idle(32'h0);
    // Write then read same word: buffered, merged, flushed on idle
    exp_w(14'h8, 4'b0000, 32'h11223344);
    w(32'h20, HSIZE_WORD, 32'h0);
    rd_q.push_back(32'h11223344);
    r(32'h20, 32'h11223344);
    chk("no_write_during_read", wr_cnt, 1);
    idle(32'h0);
    chk("flush_on_idle", wr_cnt, 2);
    idle(32'h0);
    // Byte write lane 3, immediate word read of a zero word
    exp_w(14'hC, 4'b0111, 32'hAB000000);
    w(32'h33, HSIZE_BYTE, 32'h0);
    rd_q.push_back(32'hAB000000);
    r(32'h30, 32'hAB000000); idle(32'h0);
    chk("byte_flush_timing", wr_cnt, 3);
    idle(32'h0);
    // W,R,W,R,W to distinct words
    exp_w(14'h40, 4'b0000, 32'hA1A2A3A4);
    exp_w(14'h41, 4'b0000, 32'hB1B2B3B4);
    exp_w(14'h42, 4'b0000, 32'hC1C2C3C4);
    rd_q.push_back(32'hDEADBEEF);
    rd_q.push_back(32'h11223344);
    w(32'h100, HSIZE_WORD, 32'h0);
    r(32'h10, 32'hA1A2A3A4);
    w(32'h104, HSIZE_WORD, 32'h0);
    chk("flush_during_write_addr", wr_cnt, 4);
    r(32'h20, 32'hB1B2B3B4);
    w(32'h108, HSIZE_WORD, 32'h0);
    idle(32'hC1C2C3C4);
    chk("wrwrw_writes", wr_cnt, 6);
    rd_q.push_back(32'hA1A2A3A4);
    rd_q.push_back(32'hB1B2B3B4);
    rd_q.push_back(32'hC1C2C3C4);
    r(32'h100, 32'h0); r(32'h104, 32'h0); r(32'h108, 32'h0); idle(32'h0);
    // Half write upper lanes while reading a different word: no merge
    exp_w(14'h10, 4'b0011, 32'h55660000);
    rd_q.push_back(32'hDEADBEEF);
    w(32'h42, HSIZE_HALF, 32'h0);
    r(32'h10, 32'h55660000); idle(32'h0);
    chk("half_flush_timing", wr_cnt, 7);
    rd_q.push_back(32'h55660000);
    r(32'h40, 32'h0); idle(32'h0);
    // Reset while a write sits in the buffer: it must be discarded
    w(32'h10, HSIZE_WORD, 32'h0);
    r(32'h24, 32'h12345678);
    chk("buffer_loaded", {31'b0, dut.buf_valid}, 32'd1);
    HRESETn = 1'b0; HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0;
    #1 chk_idle("async_reset");
    @(posedge HCLK); @(posedge HCLK); #1 HRESETn = 1'b1;
    idle(32'h0); idle(32'h0);
    chk("no_write_after_reset", wr_cnt, 7);
    rd_q.push_back(32'hDEADBEEF);
    r(32'h10, 32'h0); idle(32'h0); idle(32'h0);
    chk("rd_q_drained", 32'(rd_q.size()), 32'd0);
    chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
